// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   UART_BYTE_W  : width of a received character
//   UART_TAG_W   : width of the per-byte error tag (parity + framing)
//   UART_ENTRY_W : width of one stored FIFO entry in the current build
//   uart_entry_t : one FIFO entry (byte, plus error tags when enabled)
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN (adds the error tags).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int UART_TAG_W  = 2;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int UART_TAG_EN = 1;

  // Tags ride in the upper bits so the byte keeps the low 8 bits of the entry.
  typedef struct packed {
    logic [UART_TAG_W-1:0]  err;   // err[1]=framing, err[0]=parity
    logic [UART_BYTE_W-1:0] data;
  } uart_entry_t;
`else
  localparam int UART_TAG_EN = 0;

  typedef struct packed {
    logic [UART_BYTE_W-1:0] data;
  } uart_entry_t;
`endif

  localparam int UART_ENTRY_W = UART_BYTE_W + UART_TAG_EN * UART_TAG_W;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port RAM: synchronous write, registered read. Shaped so the
// array can map onto FPGA block/LSRAM.
// Ports:
//   clk, reset_n  : clock, async active-low reset (read register only)
//   we, wr_addr, wr_data : write port
//   re, rd_addr   : read enable / address; rd_data updates on the next edge
//   rd_data       : registered read data, holds when re=0
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  uart_entry_t       wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output uart_entry_t       rd_data
);

  logic [UART_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first forwarding: a byte written into the slot being read this
  // edge (empty FIFO, or a pop that lands on the just-written slot) must
  // appear on the output one cycle later, not two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (re) begin
      if (we && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte FIFO between the UART receiver and the APB registers.
// First-word-fall-through: the head byte is presented on data_out whenever
// rx_rdy=1. A full FIFO drops incoming bytes and sets a sticky overflow.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   rx_wr, rx_data        : one-cycle write strobe and byte from the receiver
//   rd_req                : one-cycle pop request
//   clr_ovf               : clears the sticky overflow flag
//   data_out              : head byte (holds its last value when empty)
//   rx_rdy/full/afull     : non-empty, count==DEPTH, count>=AFULL_LEVEL
//   overflow              : sticky, a write was dropped
//   count                 : occupancy 0..DEPTH
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN adds rx_perr/rx_ferr inputs
// stored alongside each byte and perr_out/ferr_out aligned with data_out.
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_wr,
  input  logic [UART_BYTE_W-1:0] rx_data,
`ifdef UART_RX_FIFO_ERR_TAG_EN
  input  logic                   rx_perr,
  input  logic                   rx_ferr,
  output logic                   perr_out,
  output logic                   ferr_out,
`endif
  input  logic                   rd_req,
  input  logic                   clr_ovf,
  output logic [UART_BYTE_W-1:0] data_out,
  output logic                   rx_rdy,
  output logic                   rx_full,
  output logic                   rx_afull,
  output logic                   overflow,
  output logic [ADDR_W:0]        count
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              rd_ok;
  logic              wr_ok;
  logic              rd_en;
  uart_entry_t       wr_entry;
  uart_entry_t       rd_entry;

  // A pop needs data; a push needs room, where a same-cycle pop of a full
  // FIFO counts as room.
  always_comb begin
    rd_ok       = rd_req && (count_q != '0);
    wr_ok       = rx_wr && ((count_q != FULL_CNT) || rd_ok);
    rd_ptr_next = rd_ptr + ADDR_W'(rd_ok);
    count_next  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    // Fetch the next head whenever there will be one; otherwise the read
    // register holds so data_out keeps its last value after draining.
    rd_en       = (count_next != '0);
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = rx_data;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    wr_entry.err  = {rx_ferr, rx_perr};
`endif
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .re      (rd_en),
    .rd_addr (rd_ptr_next),
    .rd_data (rd_entry)
  );

  // Pointers wrap naturally at ADDR_W bits; flags come from the next-state
  // count so they agree with count on every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rx_rdy   <= 1'b0;
      rx_full  <= 1'b0;
      rx_afull <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count_q  <= count_next;
      rx_rdy   <= (count_next != '0);
      rx_full  <= (count_next == FULL_CNT);
      rx_afull <= (count_next >= AFULL_CNT);
    end
  end

  // Sticky overflow: a dropped write beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (rx_wr && !wr_ok) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign data_out = rd_entry.data;
  assign count    = count_q;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign perr_out = rd_entry.err[0];
  assign ferr_out = rd_entry.err[1];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based model tracks the
// expected contents, head byte and overflow flag; every falling edge the
// DUT outputs are compared against it, and directed sequences also check
// hand-computed literal values.
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN (exercises the tags).
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH       = 16;
  localparam int AFULL_LEVEL = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_wr;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rd_req;
  logic       clr_ovf;
  logic [7:0] data_out;
  logic       rx_rdy;
  logic       rx_full;
  logic       rx_afull;
  logic       overflow;
  logic [4:0] count;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  logic       perr_out;
  logic       ferr_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .ADDR_W      (4),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_wr    (rx_wr),
    .rx_data  (rx_data),
`ifdef UART_RX_FIFO_ERR_TAG_EN
    .rx_perr  (rx_perr),
    .rx_ferr  (rx_ferr),
    .perr_out (perr_out),
    .ferr_out (ferr_out),
`endif
    .rd_req   (rd_req),
    .clr_ovf  (clr_ovf),
    .data_out (data_out),
    .rx_rdy   (rx_rdy),
    .rx_full  (rx_full),
    .rx_afull (rx_afull),
    .overflow (overflow),
    .count    (count)
  );

  // Behavioural model: a queue of {ferr, perr, byte} entries.
  logic [9:0] model_q [$];
  logic [9:0] model_head;
  logic       model_ovf;
  bit         model_pop;
  bit         model_push;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_q.delete();
      model_head = '0;
      model_ovf  = 1'b0;
    end else begin
      model_pop  = rd_req && (model_q.size() > 0);
      model_push = rx_wr && ((model_q.size() < DEPTH) || model_pop);
      if (model_pop) void'(model_q.pop_front());
      if (model_push) model_q.push_back({rx_ferr, rx_perr, rx_data});
      if (rx_wr && !model_push) model_ovf = 1'b1;
      else if (clr_ovf) model_ovf = 1'b0;
      if (model_q.size() > 0) model_head = model_q[0];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs from a falling edge; strobes drop afterwards.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                               input logic clr, input logic pe, input logic fe);
    rx_wr   = wr;
    rx_data = d;
    rd_req  = rd;
    clr_ovf = clr;
    rx_perr = pe;
    rx_ferr = fe;
    @(negedge clk);
    rx_wr   = 1'b0;
    rd_req  = 1'b0;
    clr_ovf = 1'b0;
    rx_perr = 1'b0;
    rx_ferr = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("cyc_count", 16'(count), 16'(model_q.size()));
    checkOutput("cyc_rdy", 16'(rx_rdy), 16'(model_q.size() != 0));
    checkOutput("cyc_full", 16'(rx_full), 16'(model_q.size() == DEPTH));
    checkOutput("cyc_afull", 16'(rx_afull), 16'(model_q.size() >= AFULL_LEVEL));
    checkOutput("cyc_ovf", 16'(overflow), 16'(model_ovf));
    checkOutput("cyc_data", 16'(data_out), 16'(model_head[7:0]));
`ifdef UART_RX_FIFO_ERR_TAG_EN
    checkOutput("cyc_perr", 16'(perr_out), 16'(model_head[8]));
    checkOutput("cyc_ferr", 16'(ferr_out), 16'(model_head[9]));
`endif
  end

  initial begin
    reset_n = 1'b0;
    rx_wr   = 1'b0;
    rx_data = 8'h00;
    rd_req  = 1'b0;
    clr_ovf = 1'b0;
    rx_perr = 1'b0;
    rx_ferr = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_count", 16'(count), 16'h0);
    checkOutput("rst_rdy", 16'(rx_rdy), 16'h0);
    checkOutput("rst_data", 16'(data_out), 16'h00);
    checkOutput("rst_ovf", 16'(overflow), 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte through
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_data", 16'(data_out), 16'hA5);
    checkOutput("a5_rdy", 16'(rx_rdy), 16'h1);
    checkOutput("a5_count", 16'(count), 16'h1);
    checkOutput("model_a5_size", 16'(model_q.size()), 16'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("a5pop_rdy", 16'(rx_rdy), 16'h0);
    checkOutput("a5pop_count", 16'(count), 16'h0);
    checkOutput("a5pop_data_hold", 16'(data_out), 16'hA5);

    // Fill, overflow, clear-vs-set priority, drain in order
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("fill_afull", 16'(rx_afull), 16'((i + 1) >= 12));
      checkOutput("fill_full", 16'(rx_full), 16'((i + 1) == 16));
    end
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set", 16'(overflow), 16'h1);
    checkOutput("ovf_count", 16'(count), 16'd16);
    checkOutput("ovf_head", 16'(data_out), 16'h00);
    checkOutput("model_ovf_set", 16'(model_ovf), 16'h1);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_set_wins", 16'(overflow), 16'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_clear", 16'(overflow), 16'h0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", 16'(data_out), 16'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("drain_count", 16'(count), 16'h0);
    checkOutput("drain_rdy", 16'(rx_rdy), 16'h0);

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_head", 16'(data_out), 16'h00);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fullrw_ovf", 16'(overflow), 16'h0);
    checkOutput("fullrw_count", 16'(count), 16'd16);
    checkOutput("fullrw_next", 16'(data_out), 16'h01);
    for (int i = 1; i < 16; i++) begin
      checkOutput("fullrw_order", 16'(data_out), 16'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("fullrw_last", 16'(data_out), 16'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Empty FIFO: read ignored, then write+read together
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("empty_rd_count", 16'(count), 16'h0);
    checkOutput("empty_rd_rdy", 16'(rx_rdy), 16'h0);
    checkOutput("empty_rd_data", 16'(data_out), 16'h77);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("empty_rw_count", 16'(count), 16'h1);
    checkOutput("empty_rw_data", 16'(data_out), 16'h5A);
    checkOutput("empty_rw_rdy", 16'(rx_rdy), 16'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_FIFO_ERR_TAG_EN
    // Error tags follow their bytes
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tag0_data", 16'(data_out), 16'h3C);
    checkOutput("tag0_perr", 16'(perr_out), 16'h1);
    checkOutput("tag0_ferr", 16'(ferr_out), 16'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("tag1_data", 16'(data_out), 16'h3D);
    checkOutput("tag1_perr", 16'(perr_out), 16'h0);
    checkOutput("tag1_ferr", 16'(ferr_out), 16'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a cycle
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 16'(count), 16'h2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 16'(count), 16'h0);
    checkOutput("async_rst_rdy", 16'(rx_rdy), 16'h0);
    checkOutput("async_rst_data", 16'(data_out), 16'h00);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_data", 16'(data_out), 16'h33);
    checkOutput("post_rst_count", 16'(count), 16'h1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART async receiver.
- Accepts one-cycle write strobes carrying a received byte from the receiver.
- Holds up to DEPTH bytes and presents them first-word-fall-through to the APB register interface.
- Reports ready, full, almost-full and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH); must be consistent with DEPTH.
- AFULL_LEVEL, 12, count at or above which rx_afull asserts; range 1..DEPTH.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_wr  input  1  one-cycle write strobe from the receiver.
- rx_data  input  8  received byte; valid with rx_wr.
- rd_req  input  1  one-cycle pop request from the register interface.
- clr_ovf  input  1  clears the sticky overflow flag.
- data_out  output  8  head-of-FIFO byte; valid while rx_rdy=1.
- rx_rdy  output  1  FIFO non-empty.
- rx_full  output  1  count==DEPTH.
- rx_afull  output  1  count>=AFULL_LEVEL.
- overflow  output  1  sticky; a write was dropped.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: reset is asynchronous and active-low on reset_n, with a single clock clk. Asserting reset_n low clears the pointers, count=0, data_out=8'h00, rx_rdy=0, rx_full=0, rx_afull=0, overflow=0. Memory contents are don't-care.
- Storage: DEPTH×8 array, write pointer and read pointer of ADDR_W bits each, plus a count register of ADDR_W+1 bits. Pointers wrap modulo DEPTH naturally; no special case at DEPTH-1 to 0.
- Write:
  - rx_wr=1 and count<DEPTH: store at wr_ptr, wr_ptr+1, count+1.
  - rx_wr=1 and count==DEPTH with no accepted read in the same cycle: byte dropped, overflow<=1, pointers unchanged.
- Read: rd_req=1 and count>0 pops the head (rd_ptr+1, count-1). rd_req while empty is ignored; no underflow flag and no state change.
- Simultaneous write and read:
  - count==0: write accepted, read ignored, count becomes 1.
  - 0<count<DEPTH: both accepted, count unchanged.
  - count==DEPTH: read frees a slot, write accepted, count stays DEPTH, no overflow.
- data_out (registered, first-word-fall-through):
  - Reflects mem[rd_ptr] from the cycle after the FIFO becomes non-empty or after a pop.
  - A byte written into an empty FIFO appears on data_out with rx_rdy=1 exactly one cycle after the rx_wr edge.
  - After a pop with count>1, the next byte is valid one cycle after rd_req.
  - When the FIFO goes empty, data_out holds its last value.
- rx_rdy, rx_full and rx_afull are registered and derived from the next-state count, so they are coherent with count on the same cycle.
- Overflow: set by a dropped write; cleared by clr_ovf. If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation discards all buffered data immediately (asynchronous).

Optional Feature:
- Macro: UART_RX_FIFO_ERR_TAG_EN.
- Defined:
  - Adds inputs rx_perr and rx_ferr (1 bit each, sampled with rx_wr).
  - Each entry widens to 10 bits.
  - Adds outputs perr_out and ferr_out, aligned with data_out and under the same first-word-fall-through timing.
  - Both new outputs reset to 0.
- Undefined: the ports are absent, the array is 8 bits wide, and the receiver's sticky error flags are the only error reporting.

Decomposition:
- Shared package uart_pkg: UART_BYTE_W=8, the error-tag width, and the entry typedef (byte plus optional tags).
- One natural sub-module, uart_fifo_mem: a simple dual-port RAM with synchronous write and registered read, so the array can map to FPGA LSRAM. Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 8'hA5: rx_rdy=1 and data_out=8'hA5 one cycle later, count=1; rd_req gives rx_rdy=0 and count=0 next cycle.
- Write 16 bytes 8'h00..8'h0F: rx_afull asserts at the 12th write and rx_full at the 16th. A 17th write of 8'hFF sets overflow; popping all 16 returns 00..0F in order with 8'hFF absent.
- Fill to 16, then rx_wr plus rd_req in the same cycle: no overflow, count stays 16, and the popped value is 8'h00.
- Empty FIFO, rd_req only: count stays 0, rx_rdy=0, data_out unchanged. Then rx_wr and rd_req together: count=1 and the written byte is on data_out.
- Overflow set, then clr_ovf together with another dropped write: overflow stays 1. clr_ovf alone the next cycle: overflow=0.
- With UART_RX_FIFO_ERR_TAG_EN: write 8'h3C with rx_perr=1, then 8'h3D with rx_ferr=1. The pops show perr_out/ferr_out = 1/0 and then 0/1, aligned with the data.
